// File: rtl/uart_tx_ctrl_if.sv
// Parallel-side handshake and serial-line bundle for the UART TX controller.
// The system side (FIFO/register file) is the master; the controller is the slave.
interface uart_tx_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  TX_OUT;
    logic                  busy;
    logic                  tx_done;

    modport master (
        output P_DATA, data_valid, par_en, par_typ,
        input  TX_OUT, busy, tx_done
    );

    modport slave (
        input  P_DATA, data_valid, par_en, par_typ,
        output TX_OUT, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, LSB-first data, optional parity, stop bit.
// One bit per clk; every output comes straight from a flop.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus
);
    localparam int unsigned    CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pen_q, pen_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    assign bus.TX_OUT  = tx_q;
    assign bus.busy    = busy_q;
    assign bus.tx_done = done_q;

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; tx_d is the line level of the state being entered
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        pen_d   = pen_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.data_valid) begin
                    state_d = START;
                    sh_d    = bus.P_DATA;
                    pen_d   = bus.par_en;
                    // Parity bit is fixed from the captured byte; odd type inverts it
                    par_d   = (^bus.P_DATA) ^ bus.par_typ;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                tx_d    = sh_q[0];
                sh_d    = sh_q >> 1;
                busy_d  = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    if (pen_q) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                end
            end
            PARITY: begin
                state_d = STOP;
                busy_d  = 1'b1;
            end
            STOP: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames plus randomized frames
// compared against a bit-list frame model.
module tb_uart_tx_ctrl;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   exp_q[$];

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line levels from start bit through stop bit
    task automatic build_frame(input logic [DW-1:0] d, input bit pe, input bit pt);
        int ones;
        exp_q.delete();
        exp_q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < int'(DW); i++) begin
            exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (pe) exp_q.push_back(pt ? bit'((ones % 2) == 0) : bit'((ones % 2) == 1));
        exp_q.push_back(1'b1);
    endtask

    task automatic drive(input logic [DW-1:0] d, input bit v, input bit pe, input bit pt);
        bus.P_DATA     = d;
        bus.data_valid = v;
        bus.par_en     = pe;
        bus.par_typ    = pt;
    endtask

    // Called at the negedge of the START cycle; returns at the negedge of the first IDLE cycle
    task automatic check_frame(input string tag, input bit disturb, input bit keep_valid);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 16'(bus.TX_OUT), 16'(exp_q[i]));
            chk($sformatf("%s_busy%0d", tag, i), 16'(bus.busy), 16'd1);
            if (disturb)
                drive(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            else if (!keep_valid)
                bus.data_valid = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_done"}, 16'(bus.tx_done), 16'd1);
        chk({tag, "_busy_low"}, 16'(bus.busy), 16'd0);
        chk({tag, "_idle_line"}, 16'(bus.TX_OUT), 16'd1);
    endtask

    task automatic send(input string tag, input logic [DW-1:0] d, input bit pe, input bit pt,
                        input bit disturb);
        build_frame(d, pe, pt);
        chk({tag, "_pre_busy"}, 16'(bus.busy), 16'd0);
        drive(d, 1'b1, pe, pt);
        @(negedge clk);
        check_frame(tag, disturb, 1'b0);
        bus.data_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_done_clr"}, 16'(bus.tx_done), 16'd0);
        chk({tag, "_stay_idle"}, 16'(bus.busy), 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive('0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset asserted mid-cycle while idle
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", 16'(bus.TX_OUT), 16'd1);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_done", 16'(bus.tx_done), 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle_tx%0d", i), 16'(bus.TX_OUT), 16'd1);
            chk($sformatf("idle_busy%0d", i), 16'(bus.busy), 16'd0);
            chk($sformatf("idle_done%0d", i), 16'(bus.tx_done), 16'd0);
        end

        // Directed parity cases
        send("even_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        send("odd_a5",  8'hA5, 1'b1, 1'b1, 1'b0);
        send("odd_00",  8'h00, 1'b1, 1'b1, 1'b0);
        send("even_ff", 8'hFF, 1'b1, 1'b0, 1'b0);

        // Inputs churn during the frame, including extra data_valid pulses
        send("nopar_07", 8'h07, 1'b0, 1'b0, 1'b1);

        // Back-to-back with data_valid held high
        build_frame(8'h3C, 1'b1, 1'b0);
        drive(8'h3C, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bus.P_DATA = 8'hC3;
        check_frame("b2b_1", 1'b0, 1'b1);
        @(negedge clk);
        build_frame(8'hC3, 1'b1, 1'b0);
        check_frame("b2b_2", 1'b0, 1'b1);
        bus.data_valid = 1'b0;
        @(negedge clk);
        chk("b2b_done_clr", 16'(bus.tx_done), 16'd0);
        chk("b2b_stay_idle", 16'(bus.busy), 16'd0);

        // Reset during data bit 4 of 0x5A
        drive(8'h5A, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_bit4", 16'(bus.TX_OUT), 16'd1);
        chk("mid_busy_pre", 16'(bus.busy), 16'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", 16'(bus.TX_OUT), 16'd1);
        chk("mid_rst_busy", 16'(bus.busy), 16'd0);
        chk("mid_rst_done", 16'(bus.tx_done), 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_idle_tx", 16'(bus.TX_OUT), 16'd1);
            chk("post_rst_idle_busy", 16'(bus.busy), 16'd0);
        end
        send("after_rst_81", 8'h81, 1'b1, 1'b0, 1'b0);

        // Randomized frames with random framing and churning inputs
        for (int n = 0; n < 20; n++)
            send($sformatf("rnd%0d", n), DW'($urandom), 1'($urandom), 1'($urandom), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
